rv_timer: RTL and testbench

RV_TIMER -- requirements
Module: rv_timer

---
 rtl/rv_types.sv | 29 ++
 rtl/rv_timer.sv | 140 ++++++++++++++
 tb/tb_rv_timer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_types.sv
// rv_types -- shared types and constants for the rv_* peripherals.
//   u32_t / u4_t     : bus data word and byte-enable types
//   TMR_* offsets    : rv_timer register byte offsets (word aligned)
//   CTRL_* indices   : rv_timer CTRL bit positions
//   merge_bytes()    : apply a byte-lane write onto an existing word
package rv_types;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;

    localparam logic [4:0] TMR_CTRL  = 5'h00;
    localparam logic [4:0] TMR_PRESC = 5'h04;
    localparam logic [4:0] TMR_CMP   = 5'h08;
    localparam logic [4:0] TMR_COUNT = 5'h0C;
    localparam logic [4:0] TMR_STAT  = 5'h10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;

    function automatic u32_t merge_bytes(input u32_t cur, input u32_t wdata, input u4_t be);
        u32_t res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_timer.sv
// rv_timer -- prescaled 32-bit up-counter with compare match interrupt.
//   clk    : single clock, rising edge
//   xreset : asynchronous active-low reset
//   adr    : byte address in the 32-byte window (adr[1:0] ignored)
//   cs     : chip select
//   we     : byte write enables
//   re     : read enable
//   dw     : write data
//   dr     : registered read data, 0 unless the previous cycle was cs&re
//   irq    : registered level interrupt, PEND & IE
module rv_timer
    import rv_types::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        irq
);

    logic               en;
    logic               ie;
    logic               oneshot;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    u32_t               cmp;
    u32_t               count;
    logic               pend;

    logic [4:0] ofs;
    logic       wr;
    logic       wr_ctrl;
    logic       wr_presc;
    logic       wr_cmp;
    logic       wr_count;
    logic       wr_stat;
    logic [2:0] ctrl_new;
    logic       en_rise;
    logic       tick;
    logic       match;
    logic       pend_set;
    logic       pend_clr;
    u32_t       rdata;
    logic       unused_adr;

    assign ofs        = {adr[4:2], 2'b00};
    assign unused_adr = ^adr[1:0];

    assign wr       = cs & (we != 4'h0);
    assign wr_ctrl  = wr & (ofs == TMR_CTRL);
    assign wr_presc = wr & (ofs == TMR_PRESC);
    assign wr_cmp   = wr & (ofs == TMR_CMP);
    assign wr_count = wr & (ofs == TMR_COUNT);
    assign wr_stat  = wr & (ofs == TMR_STAT);

    // All CTRL bits live in byte lane 0.
    assign ctrl_new = we[0] ? dw[2:0] : {oneshot, ie, en};
    assign en_rise  = wr_ctrl & ctrl_new[CTRL_EN] & ~en;

    assign tick  = en & (pcnt == '0);
    // Compare uses the current CMP, so a CMP write in this cycle only affects later ticks.
    assign match = tick & (count == cmp);
    // A COUNT write in the same cycle overrides the match entirely.
    assign pend_set = match & ~wr_count;
    assign pend_clr = wr_stat & we[0] & dw[0];

    always_comb begin
        rdata = '0;
        case (ofs)
            TMR_CTRL:  rdata = {29'b0, oneshot, ie, en};
            TMR_PRESC: rdata = u32_t'(presc);
            TMR_CMP:   rdata = cmp;
            TMR_COUNT: rdata = count;
            TMR_STAT:  rdata = {31'b0, pend};
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
            presc   <= '0;
            pcnt    <= '0;
            cmp     <= 32'hFFFF_FFFF;
            count   <= '0;
            pend    <= 1'b0;
            irq     <= 1'b0;
            dr      <= '0;
        end else begin
            // Prescaler: an enabling CTRL write restarts the period from PRESC.
            if (en_rise) begin
                pcnt <= presc;
            end else if (en) begin
                pcnt <= tick ? presc : pcnt - PRESC_W'(1);
            end

            // A CTRL write takes precedence over the oneshot auto-disable.
            if (wr_ctrl) begin
                en      <= ctrl_new[CTRL_EN];
                ie      <= ctrl_new[CTRL_IE];
                oneshot <= ctrl_new[CTRL_ONESHOT];
            end else if (pend_set && oneshot) begin
                en <= 1'b0;
            end

            if (wr_presc) begin
                presc <= PRESC_W'(merge_bytes(u32_t'(presc), dw, we));
            end

            if (wr_cmp) begin
                cmp <= merge_bytes(cmp, dw, we);
            end

            if (wr_count) begin
                count <= merge_bytes(count, dw, we);
            end else if (tick) begin
                count <= match ? 32'd0 : count + 32'd1;
            end

            // Set beats a simultaneous software clear.
            if (pend_set) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            irq <= pend & ie;
            dr  <= (cs && re) ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_rv_timer.sv
// tb_rv_timer -- directed scenarios plus randomized bus traffic for rv_timer,
// checked against a cycle-level behavioural model of the register rules.
module tb_rv_timer;

    localparam int          PW         = 16;
    localparam logic [31:0] PRESC_MASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        xreset;
    logic [4:0]  adr;
    logic        cs;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr;
    logic        irq;

    int checks = 0;
    int failures = 0;

    rv_timer #(.PRESC_W(PW)) dut (
        .clk    (clk),
        .xreset (xreset),
        .adr    (adr),
        .cs     (cs),
        .we     (we),
        .re     (re),
        .dw     (dw),
        .dr     (dr),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_en, m_ie, m_os, m_pend, m_irq;
    bit [31:0]   m_presc, m_pcnt, m_cmp, m_count, m_dr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] lanes(input bit [31:0] cur, input bit [31:0] d, input bit [3:0] w);
        bit [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (w[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit [31:0] m_read(input int word);
        case (word)
            0:       return {29'b0, m_os, m_ie, m_en};
            1:       return m_presc;
            2:       return m_cmp;
            3:       return m_count;
            4:       return {31'b0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_os = 0; m_pend = 0; m_irq = 0;
        m_presc = 0; m_pcnt = 0; m_cmp = 32'hFFFF_FFFF; m_count = 0; m_dr = 0;
    endtask

    // One clock edge of the register rules, evaluated from pre-edge state.
    task automatic model_step(input bit [4:0] a, input bit c, input bit [3:0] w,
                              input bit r, input bit [31:0] d);
        int        word;
        bit        is_wr, tick, hit;
        bit [31:0] rdv, nv;
        bit        n_en, n_ie, n_os, n_pend;
        bit [31:0] n_presc, n_pcnt, n_cmp, n_count;
        word  = int'(a[4:2]);
        is_wr = c && (w != 0);
        rdv   = m_read(word);
        n_en = m_en; n_ie = m_ie; n_os = m_os; n_pend = m_pend;
        n_presc = m_presc; n_pcnt = m_pcnt; n_cmp = m_cmp; n_count = m_count;

        tick = m_en && (m_pcnt == 0);
        hit  = tick && (m_count == m_cmp) && !(is_wr && word == 3);
        if (m_en) n_pcnt = tick ? m_presc : m_pcnt - 1;
        if (tick) n_count = (m_count == m_cmp) ? 32'd0 : m_count + 32'd1;
        if (hit) begin
            n_pend = 1;
            if (m_os) n_en = 0;
        end

        if (is_wr) begin
            case (word)
                0: begin
                    nv   = lanes(m_read(0), d, w);
                    n_en = nv[0]; n_ie = nv[1]; n_os = nv[2];
                    if (nv[0] && !m_en) n_pcnt = m_presc;
                end
                1: n_presc = lanes(m_presc, d, w) & PRESC_MASK;
                2: n_cmp   = lanes(m_cmp, d, w);
                3: n_count = lanes(m_count, d, w);
                4: if (w[0] && d[0] && !hit) n_pend = 0;
                default: ;
            endcase
        end

        m_irq = m_pend && m_ie;
        m_dr  = (c && r) ? rdv : 32'd0;
        m_en = n_en; m_ie = n_ie; m_os = n_os; m_pend = n_pend;
        m_presc = n_presc; m_pcnt = n_pcnt; m_cmp = n_cmp; m_count = n_count;
    endtask

    task automatic bus(input bit [4:0] a, input bit c, input bit [3:0] w,
                       input bit r, input bit [31:0] d);
        adr = a; cs = c; we = w; re = r; dw = d;
        @(posedge clk);
        model_step(a, c, w, r, d);
        #1;
        chk("dr_model", dr, m_dr);
        chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
        adr = 0; cs = 0; we = 0; re = 0; dw = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus(5'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input bit [4:0] a, input bit [31:0] d);
        bus(a, 1'b1, 4'hF, 1'b0, d);
    endtask

    task automatic rd_exp(input string tag, input bit [4:0] a, input logic [31:0] exp);
        bus(a, 1'b1, 4'h0, 1'b1, 32'h0);
        chk(tag, dr, exp);
    endtask

    // Assert reset between clock edges, check outputs clear at once, then release.
    task automatic apply_reset();
        #3;
        xreset = 1'b0;
        #1;
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_dr", dr, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #5;
        xreset = 1'b1;
    endtask

    task automatic check_reset_values();
        rd_exp("rv_ctrl", 5'h00, 32'h0);
        rd_exp("rv_presc", 5'h04, 32'h0);
        rd_exp("rv_cmp", 5'h08, 32'hFFFF_FFFF);
        rd_exp("rv_count", 5'h0C, 32'h0);
        rd_exp("rv_stat", 5'h10, 32'h0);
    endtask

    initial begin
        bit [4:0]  ra;
        bit [31:0] rdw;
        bit [3:0]  rwe;
        bit        rcs, rre;

        xreset = 1'b0; adr = 0; cs = 0; we = 0; re = 0; dw = 0;
        model_reset();
        #1;
        chk("por_dr", dr, 32'd0);
        chk("por_irq", {31'b0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #5;
        xreset = 1'b1;
        check_reset_values();

        // Basic count: tick every 4 cycles, match on the 5th tick.
        wr(5'h04, 32'd3);
        wr(5'h08, 32'd4);
        wr(5'h00, 32'h3);
        idle(19);
        chk("basic_irq_before", {31'b0, irq}, 32'd0);
        idle(1);
        chk("basic_irq_tick5", {31'b0, irq}, 32'd0);
        idle(1);
        chk("basic_irq_after", {31'b0, irq}, 32'd1);
        rd_exp("basic_count", 5'h0C, 32'd0);
        rd_exp("basic_pend", 5'h10, 32'd1);
        rd_exp("basic_cmp", 5'h08, 32'd4);

        // Async reset mid-count with irq and dr both nonzero.
        apply_reset();
        check_reset_values();
        idle(10);
        rd_exp("rst_no_resume", 5'h0C, 32'd0);

        // Oneshot.
        apply_reset();
        wr(5'h08, 32'd2);
        wr(5'h00, 32'h7);
        idle(23);
        rd_exp("os_ctrl", 5'h00, 32'h6);
        rd_exp("os_count", 5'h0C, 32'd0);
        rd_exp("os_pend", 5'h10, 32'd1);

        // Set/clear race on PEND.
        apply_reset();
        wr(5'h08, 32'd2);
        wr(5'h00, 32'h3);
        idle(2);
        bus(5'h10, 1'b1, 4'h1, 1'b0, 32'h1);
        rd_exp("race_pend_set_wins", 5'h10, 32'd1);
        wr(5'h00, 32'h2);
        wr(5'h10, 32'h1);
        chk("race_irq_still", {31'b0, irq}, 32'd1);
        idle(1);
        chk("race_irq_clr", {31'b0, irq}, 32'd0);
        rd_exp("race_pend_clr", 5'h10, 32'd0);

        // Byte lanes, read latency, unmapped offsets, width masking.
        apply_reset();
        bus(5'h08, 1'b1, 4'b0101, 1'b0, 32'hAABB_CCDD);
        rd_exp("lanes_cmp", 5'h08, 32'hFFBB_FFDD);
        wr(5'h0C, 32'h1234_5678);
        bus(5'h0C, 1'b1, 4'h0, 1'b1, 32'h0);
        chk("lat_n1", dr, 32'h1234_5678);
        idle(1);
        chk("lat_n2", dr, 32'h0);
        bus(5'h0C, 1'b1, 4'h0, 1'b0, 32'hDEAD_BEEF);
        rd_exp("we0_no_write", 5'h0C, 32'h1234_5678);
        wr(5'h14, 32'hFFFF_FFFF);
        rd_exp("unmapped_14", 5'h14, 32'h0);
        rd_exp("unmapped_1c", 5'h1C, 32'h0);
        wr(5'h04, 32'hFFFF_FFFF);
        rd_exp("presc_mask", 5'h04, 32'h0000_FFFF);
        rd_exp("ctrl_addr_alias", 5'h03, 32'h0);

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) apply_reset();
            if ($urandom_range(0, 9) < 4) begin
                idle(1);
            end else begin
                ra  = 5'($urandom_range(0, 31));
                rcs = ($urandom_range(0, 7) != 0);
                rwe = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                rre = ($urandom_range(0, 1) != 0);
                case (ra[4:2])
                    3'd0:       rdw = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(1, 7)) | 32'h1
                                                                  : 32'($urandom_range(0, 7));
                    3'd1:       rdw = 32'($urandom_range(0, 3));
                    3'd2, 3'd3: rdw = 32'($urandom_range(0, 6));
                    3'd4:       rdw = 32'($urandom_range(0, 1));
                    default:    rdw = $urandom;
                endcase
                bus(ra, rcs, rwe, rre, rdw);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
